// File: rtl/time_set_ctrl_if.sv
// Strobe and button bundle between the strobe generator,
// the set buttons and the time-set sequencer.
interface time_set_ctrl_if;
    logic i_en;
    logic i_1hz_stb;
    logic i_slow_set_stb;
    logic i_fast_set_stb;
    logic i_btn_hours;
    logic i_btn_minutes;
    logic o_sec_inc_stb;
    logic o_min_inc_stb;
    logic o_hour_inc_stb;
    logic o_sec_clr;
    logic o_setting;

    modport master (
        output i_en,
        output i_1hz_stb,
        output i_slow_set_stb,
        output i_fast_set_stb,
        output i_btn_hours,
        output i_btn_minutes,
        input  o_sec_inc_stb,
        input  o_min_inc_stb,
        input  o_hour_inc_stb,
        input  o_sec_clr,
        input  o_setting
    );

    modport slave (
        input  i_en,
        input  i_1hz_stb,
        input  i_slow_set_stb,
        input  i_fast_set_stb,
        input  i_btn_hours,
        input  i_btn_minutes,
        output o_sec_inc_stb,
        output o_min_inc_stb,
        output o_hour_inc_stb,
        output o_sec_clr,
        output o_setting
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Routes 1 Hz / slow-set / fast-set strobes into seconds,
// minutes and hours increment strobes while set buttons are held.
module time_set_ctrl #(
    parameter int unsigned FAST_THRESHOLD = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    time_set_ctrl_if.slave  bus
);
    localparam int unsigned CW = $clog2(FAST_THRESHOLD + 1);
    localparam logic [CW-1:0] FT_C = CW'(FAST_THRESHOLD);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_SLOW = 2'd1,
        SET_FAST = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        TGT_NONE = 2'd0,
        TGT_MIN  = 2'd1,
        TGT_HOUR = 2'd2
    } tgt_e;

    state_e        state_q, state_d;
    tgt_e          tgt_q, tgt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          btn_h_q, btn_h_d;
    logic          btn_m_q, btn_m_d;
    logic          sec_inc_q, sec_inc_d;
    logic          min_inc_q, min_inc_d;
    logic          hour_inc_q, hour_inc_d;
    logic          sec_clr_q, sec_clr_d;
    logic          setting_q, setting_d;

    logic rise;
    logic tgt_held;
    logic inc;

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;
        btn_h_d  = bus.i_btn_hours;
        btn_m_d  = bus.i_btn_minutes;
        inc      = 1'b0;
        sec_inc_d = 1'b0;
        rise     = (bus.i_btn_hours & ~btn_h_q)
                 | (bus.i_btn_minutes & ~btn_m_q);
        tgt_held = (tgt_q == TGT_HOUR) ? bus.i_btn_hours
                                       : bus.i_btn_minutes;

        if (!bus.i_en) begin
            state_d = RUN;
            tgt_d   = TGT_NONE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (rise) begin
                        state_d = SET_SLOW;
                        cnt_d   = '0;
                        tgt_d   = bus.i_btn_hours ? TGT_HOUR : TGT_MIN;
                        inc     = 1'b1;
                    end else begin
                        sec_inc_d = bus.i_1hz_stb;
                    end
                end
                SET_SLOW: begin
                    if (!tgt_held) begin
                        state_d = RUN;
                        tgt_d   = TGT_NONE;
                        cnt_d   = '0;
                    end else if (bus.i_slow_set_stb) begin
                        inc = 1'b1;
                        if (cnt_q != FT_C) cnt_d = cnt_q + 1'b1;
                        if (cnt_q + 1'b1 == FT_C) state_d = SET_FAST;
                    end
                end
                SET_FAST: begin
                    if (!tgt_held) begin
                        state_d = RUN;
                        tgt_d   = TGT_NONE;
                        cnt_d   = '0;
                    end else begin
                        inc = bus.i_fast_set_stb;
                    end
                end
                default: begin
                    state_d = RUN;
                    tgt_d   = TGT_NONE;
                    cnt_d   = '0;
                end
            endcase
        end

        hour_inc_d = inc & (tgt_d == TGT_HOUR);
        min_inc_d  = inc & (tgt_d == TGT_MIN);
        // the first minutes strobe of a hold also zeroes seconds
        sec_clr_d  = min_inc_d & (state_q == RUN);
        setting_d  = (state_d != RUN);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= RUN;
            tgt_q      <= TGT_NONE;
            cnt_q      <= '0;
            btn_h_q    <= 1'b0;
            btn_m_q    <= 1'b0;
            sec_inc_q  <= 1'b0;
            min_inc_q  <= 1'b0;
            hour_inc_q <= 1'b0;
            sec_clr_q  <= 1'b0;
            setting_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            cnt_q      <= cnt_d;
            btn_h_q    <= btn_h_d;
            btn_m_q    <= btn_m_d;
            sec_inc_q  <= sec_inc_d;
            min_inc_q  <= min_inc_d;
            hour_inc_q <= hour_inc_d;
            sec_clr_q  <= sec_clr_d;
            setting_q  <= setting_d;
        end
    end

    assign bus.o_sec_inc_stb  = sec_inc_q;
    assign bus.o_min_inc_stb  = min_inc_q;
    assign bus.o_hour_inc_stb = hour_inc_q;
    assign bus.o_sec_clr      = sec_clr_q;
    assign bus.o_setting      = setting_q;
endmodule
